// File: rtl/alu_seq_ctrl_if.sv
// Command/result and adder-drive bundle between the CPU control FSM, the sequencer and the adder.
// With ALU_FLAGS_EN defined, the bundle also carries the flag_z/flag_v result flags.
interface alu_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic                  busy;
  logic                  done;
  logic [2*DATA_W-1:0]   result;
  logic                  carry;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic                  alu_cin;
  logic [DATA_W-1:0]     alu_sum;
  logic                  alu_cout;
`ifdef ALU_FLAGS_EN
  logic                  flag_z;
  logic                  flag_v;

  modport slave (
    input  start, op, op_a, op_b, alu_sum, alu_cout,
    output busy, done, result, carry, alu_a, alu_b, alu_cin, flag_z, flag_v
  );
  modport master (
    output start, op, op_a, op_b, alu_sum, alu_cout,
    input  busy, done, result, carry, alu_a, alu_b, alu_cin, flag_z, flag_v
  );
`else
  modport slave (
    input  start, op, op_a, op_b, alu_sum, alu_cout,
    output busy, done, result, carry, alu_a, alu_b, alu_cin
  );
  modport master (
    output start, op, op_a, op_b, alu_sum, alu_cout,
    input  busy, done, result, carry, alu_a, alu_b, alu_cin
  );
`endif
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer owning a shared combinational adder: ADD/SUB in one cycle, shift-add MUL in DATA_W cycles.
// Optional feature macro ALU_FLAGS_EN adds registered zero/overflow flags.
module alu_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int MSB   = DATA_W - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic [DATA_W-1:0]     r_a;
  // r_plo holds operand B for ADD/SUB and the low product half during MUL.
  logic [DATA_W-1:0]     r_plo;
  logic [DATA_W-1:0]     r_phi;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_carry;
`ifdef ALU_FLAGS_EN
  logic                  r_flag_z;
  logic                  r_flag_v;
`endif

  logic [DATA_W-1:0]     w_alu_a;
  logic [DATA_W-1:0]     w_alu_b;
  logic                  w_alu_cin;
  logic [DATA_W-1:0]     w_phi_next;
  logic [DATA_W-1:0]     w_plo_next;
  logic                  w_ovf;
  logic                  w_mul_last;

  // Adder drive comes only from registered state, so there is no input-to-adder path.
  always_comb begin
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_alu_cin = 1'b0;
    case (r_state)
      S_EXEC: begin
        case (r_op)
          OP_ADD: begin
            w_alu_a = r_a;
            w_alu_b = r_plo;
          end
          OP_SUB: begin
            w_alu_a   = r_a;
            w_alu_b   = ~r_plo;
            w_alu_cin = 1'b1;
          end
          default: ;
        endcase
      end
      S_MUL: begin
        w_alu_a = r_phi;
        w_alu_b = r_plo[0] ? r_a : '0;
      end
      default: ;
    endcase
  end

  assign w_phi_next = {bus.alu_cout, bus.alu_sum[MSB:1]};
  assign w_plo_next = {bus.alu_sum[0], r_plo[MSB:1]};
  assign w_ovf      = (r_a[MSB] == w_alu_b[MSB]) && (bus.alu_sum[MSB] != r_a[MSB]);
  assign w_mul_last = (r_cnt == CNT_W'(DATA_W - 1));

  assign bus.alu_a   = w_alu_a;
  assign bus.alu_b   = w_alu_b;
  assign bus.alu_cin = w_alu_cin;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.result  = r_result;
  assign bus.carry   = r_carry;
`ifdef ALU_FLAGS_EN
  assign bus.flag_z  = r_flag_z;
  assign bus.flag_v  = r_flag_v;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_plo    <= '0;
      r_phi    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
`ifdef ALU_FLAGS_EN
      r_flag_z <= 1'b0;
      r_flag_v <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (bus.start) begin
            r_op    <= bus.op;
            r_a     <= bus.op_a;
            r_plo   <= bus.op_b;
            r_phi   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= (bus.op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
          if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
            r_result <= {{DATA_W{1'b0}}, bus.alu_sum};
            r_carry  <= bus.alu_cout;
`ifdef ALU_FLAGS_EN
            r_flag_z <= (bus.alu_sum == '0);
            r_flag_v <= w_ovf;
`endif
          end else begin
            r_result <= '0;
            r_carry  <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_flag_z <= 1'b1;
            r_flag_v <= 1'b0;
`endif
          end
        end
        S_MUL: begin
          r_phi <= w_phi_next;
          r_plo <= w_plo_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_mul_last) begin
            r_result <= {w_phi_next, w_plo_next};
            r_carry  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
`ifdef ALU_FLAGS_EN
            r_flag_z <= ({w_phi_next, w_plo_next} == '0);
            r_flag_v <= (w_phi_next != '0);
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized self-checking bench for alu_seq_ctrl with a behavioural arithmetic reference model.
module tb_alu_seq_ctrl;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  logic [15:0] last_result = 16'h0;

  alu_seq_ctrl_if #(.DATA_W(DW)) bus ();

  alu_seq_ctrl #(.DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural combinational adder.
  logic [DW:0] w_add;
  assign w_add        = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{DW{1'b0}}, bus.alu_cin};
  assign bus.alu_sum  = w_add[DW-1:0];
  assign bus.alu_cout = w_add[DW];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [15:0] r, output logic c, output logic z,
                           output logic v, output int lat);
    int sa, sb, s;
    sa = (a > 127) ? int'(a) - 256 : int'(a);
    sb = (b > 127) ? int'(b) - 256 : int'(b);
    r = 16'h0; c = 1'b0; v = 1'b0; lat = 2;
    case (op)
      2'b00: begin
        s = int'(a) + int'(b);
        r = 16'(s % 256);
        c = (s > 255);
        v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      2'b01: begin
        s = int'(a) - int'(b);
        r = 16'((s + 256) % 256);
        c = (a >= b);
        v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      2'b10: begin
        r = 16'(int'(a) * int'(b));
        v = (r > 16'd255);
        lat = 9;
      end
      default: ;
    endcase
    z = (r == 16'h0);
  endtask

  // Entered at a negedge; returns at the negedge of the DONE cycle.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit inject);
    logic [15:0] er;
    logic ec, ez, ev;
    int elat, cyc;
    ref_model(op, a, b, er, ec, ez, ev, elat);
    bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
    cyc = 1;
    while (!bus.done && cyc < 20) begin
      chk("busy_during_cmd", 32'(bus.busy), 32'h1);
      chk("result_hold_busy", 32'(bus.result), 32'(last_result));
      if (cyc == 1) begin
        case (op)
          2'b00: begin
            chk("add_alu_a", 32'(bus.alu_a), 32'(a));
            chk("add_alu_b", 32'(bus.alu_b), 32'(b));
            chk("add_alu_cin", 32'(bus.alu_cin), 32'h0);
          end
          2'b01: begin
            chk("sub_alu_a", 32'(bus.alu_a), 32'(a));
            chk("sub_alu_b", 32'(bus.alu_b), 32'(8'(~b)));
            chk("sub_alu_cin", 32'(bus.alu_cin), 32'h1);
          end
          2'b10: begin
            chk("mul_alu_a", 32'(bus.alu_a), 32'h0);
            chk("mul_alu_b", 32'(bus.alu_b), b[0] ? 32'(a) : 32'h0);
          end
          default: begin
            chk("rsv_alu_a", 32'(bus.alu_a), 32'h0);
            chk("rsv_alu_b", 32'(bus.alu_b), 32'h0);
            chk("rsv_alu_cin", 32'(bus.alu_cin), 32'h0);
          end
        endcase
      end
      if (inject && cyc == 3) begin
        bus.start = 1'b1; bus.op = 2'b00; bus.op_a = 8'd1; bus.op_b = 8'd1;
      end
      if (inject && cyc == 4) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_latency", 32'(cyc), 32'(elat));
    chk("busy_in_done", 32'(bus.busy), 32'h0);
    chk("result", 32'(bus.result), 32'(er));
    chk("carry", 32'(bus.carry), 32'(ec));
`ifdef ALU_FLAGS_EN
    chk("flag_z", 32'(bus.flag_z), 32'(ez));
    chk("flag_v", 32'(bus.flag_v), 32'(ev));
`endif
    last_result = er;
    $display("txn op=%0d a=%02h b=%02h result=%04h carry=%0b latency=%0d",
             op, a, b, bus.result, bus.carry, cyc);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 32'h0);
    chk("idle_busy", 32'(bus.busy), 32'h0);
    chk("idle_alu", {15'h0, bus.alu_cin, bus.alu_a, bus.alu_b}, 32'h0);
    chk("idle_result_hold", 32'(bus.result), 32'(last_result));
  endtask

  task automatic reset_mid_mul();
    bit seen_done;
    bus.start = 1'b1; bus.op = 2'b10; bus.op_a = 8'd200; bus.op_b = 8'd77;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_carry", 32'(bus.carry), 32'h0);
    chk("rst_alu", {15'h0, bus.alu_cin, bus.alu_a, bus.alu_b}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_result = 16'h0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    chk("rst_no_done", 32'(seen_done), 32'h0);
    $display("txn reset during MUL cycle 4, result=%04h", bus.result);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.op_a = 8'h0; bus.op_b = 8'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    chk("reset_result", 32'(bus.result), 32'h0);
    chk("reset_carry", 32'(bus.carry), 32'h0);
`ifdef ALU_FLAGS_EN
    chk("reset_flags", {30'h0, bus.flag_z, bus.flag_v}, 32'h0);
`endif
    rst = 1'b0;
    idle_cycle();

    do_cmd(2'b00, 8'd10,  8'd20,  1'b0); idle_cycle();
    do_cmd(2'b00, 8'd255, 8'd1,   1'b0); idle_cycle();
    do_cmd(2'b01, 8'd50,  8'd10,  1'b0); idle_cycle();
    do_cmd(2'b01, 8'd10,  8'd20,  1'b0); idle_cycle();
    do_cmd(2'b10, 8'd100, 8'd155, 1'b0); idle_cycle();
    do_cmd(2'b10, 8'd255, 8'd255, 1'b0); idle_cycle();
    do_cmd(2'b10, 8'd37,  8'd91,  1'b1); idle_cycle();
    do_cmd(2'b10, 8'd12,  8'd13,  1'b0);
    do_cmd(2'b00, 8'd1,   8'd1,   1'b0); idle_cycle();
    do_cmd(2'b11, 8'hA5,  8'h5A,  1'b0); idle_cycle();
    reset_mid_mul();

    for (int i = 0; i < 40; i++) begin
      do_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle_cycle();
    end
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
